wired_clz_share: RTL and testbench

- Time-shares one `wired_clz` leading-zero counter between NREQ requesters, for example the divider normaliser, the FP normaliser and the bit-manip unit.
- Round-robin arbiter, one pipeline register stage in front of the counter, and one result slot per requester with valid/ready handshakes.
- At most one outstanding operation per requester; fully pipelined across different requesters.

---
 rtl/wired_clz_share_pkg.sv | 22 ++
 rtl/wired_clz.sv | 34 +++
 rtl/wired_rr_arb.sv | 38 +++
 rtl/wired_clz_share.sv | 136 +++++++++++++
 tb/tb_wired_clz_share.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wired_clz_share_pkg.sv
// -----------------------------------------------------------------------------
// wired_clz_share_pkg
// Shared sizing helpers and defaults for the time-shared leading-zero counter.
//   clz_cw(width) : width of a count that spans 0..width inclusive
//   id_w(nreq)    : width of a requester index
// -----------------------------------------------------------------------------
package wired_clz_share_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int NREQ_DEF  = 4;

  // Count range is 0..WIDTH, so one bit more than the bit-position index.
  function automatic int clz_cw(input int width);
    return $clog2(width) + 1;
  endfunction

  // Requester index width; never narrower than one bit.
  function automatic int id_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/wired_clz.sv
// -----------------------------------------------------------------------------
// wired_clz
// Combinational leading-zero counter.
//   in_i   : operand
//   clz_o  : number of zeros above the highest set bit (0 when in_i == 0)
//   zero_o : operand is all zeros
// -----------------------------------------------------------------------------
module wired_clz #(
  parameter  int WIDTH = 32,
  localparam int CLZW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CLZW-1:0]  clz_o,
  output logic             zero_o
);

  logic w_found;
  logic w_hit;

  // Scan from the MSB down; the first set bit fixes the count.
  always_comb begin
    clz_o   = '0;
    w_found = 1'b0;
    w_hit   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      w_hit   = in_i[i] & ~w_found;
      clz_o   = w_hit ? CLZW'(WIDTH - 1 - i) : clz_o;
      w_found = w_found | in_i[i];
    end
  end

  assign zero_o = ~|in_i;

endmodule

// File: rtl/wired_rr_arb.sv
// -----------------------------------------------------------------------------
// wired_rr_arb
// Purely combinational round-robin arbiter; the pointer register lives in
// the parent.
//   req_i : eligible requesters
//   ptr_i : index where the search starts (wraps upward)
//   gnt_o : one-hot grant, or zero when nothing is eligible
// -----------------------------------------------------------------------------
module wired_rr_arb
  import wired_clz_share_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o
);

  int   w_idx;
  logic w_found;
  logic w_hit;

  // Walk ptr, ptr+1, ... with wrap; the first eligible requester wins.
  always_comb begin
    gnt_o   = '0;
    w_found = 1'b0;
    w_hit   = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx        = (int'(ptr_i) + k) % NREQ;
      w_hit        = req_i[w_idx] & ~w_found;
      gnt_o[w_idx] = w_hit;
      w_found      = w_found | w_hit;
    end
  end

endmodule

// File: rtl/wired_clz_share.sv
// -----------------------------------------------------------------------------
// wired_clz_share
// Shares one leading-zero counter between NREQ requesters. A round-robin
// grant loads a single stage register, the counter works on that stage the
// next cycle, and the count lands in the requester's own result slot.
// Accept at T -> resp_valid_o at T+2. One outstanding op per requester.
//   clk, rst_n    : clock, asynchronous active-low reset
//   req_valid_i   : requester i presents an operand
//   req_data_i    : operand of requester i
//   req_ready_o   : operand of requester i accepted this cycle (one-hot/zero)
//   resp_valid_o  : result slot i holds a result
//   resp_clz_o    : leading-zero count for requester i (0..WIDTH)
//   resp_ready_i  : requester i consumes its result
// -----------------------------------------------------------------------------
module wired_clz_share
  import wired_clz_share_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int NREQ  = NREQ_DEF,
  localparam int CW    = clz_cw(WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid_i,
  input  logic [NREQ-1:0][WIDTH-1:0] req_data_i,
  output logic [NREQ-1:0]           req_ready_o,
  output logic [NREQ-1:0]           resp_valid_o,
  output logic [NREQ-1:0][CW-1:0]   resp_clz_o,
  input  logic [NREQ-1:0]           resp_ready_i
);

  localparam int IDW = id_w(NREQ);

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] data;
  } s1_payload_t;

  logic                    r_s1_v;
  s1_payload_t             r_s1;
  logic [NREQ-1:0]         r_pend;
  logic [NREQ-1:0]         r_resp_valid;
  logic [NREQ-1:0][CW-1:0] r_slot;
  logic [IDW-1:0]          r_rr_ptr;

  logic [NREQ-1:0]         w_elig;
  logic [NREQ-1:0]         w_gnt;
  logic [NREQ-1:0]         w_hs;
  logic [NREQ-1:0]         w_wb;
  logic [IDW-1:0]          w_gid;
  logic [IDW-1:0]          w_next_ptr;
  logic [$clog2(WIDTH)-1:0] w_clz;
  logic                    w_zero;
  logic [CW-1:0]           w_count;

  // Gating with rst_n keeps req_ready_o low for the whole reset.
  assign w_elig       = req_valid_i & ~r_pend & {NREQ{rst_n}};
  assign w_hs         = r_resp_valid & resp_ready_i;
  assign req_ready_o  = w_gnt;
  assign resp_valid_o = r_resp_valid;
  assign resp_clz_o   = r_slot;

  wired_rr_arb #(.NREQ(NREQ)) u_arb (
    .req_i (w_elig),
    .ptr_i (r_rr_ptr),
    .gnt_o (w_gnt)
  );

  wired_clz #(.WIDTH(WIDTH)) u_clz (
    .in_i   (r_s1.data),
    .clz_o  (w_clz),
    .zero_o (w_zero)
  );

  // One-hot grant to index, and the pointer value that follows it.
  always_comb begin
    w_gid = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_gid = w_gid | (w_gnt[i] ? IDW'(i) : IDW'(0));
    end
    if (int'(w_gid) == NREQ - 1) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = w_gid + IDW'(1);
    end
  end

  // Writeback target slot and final count (all-zero operand counts WIDTH).
  always_comb begin
    w_wb = '0;
    if (r_s1_v) begin
      w_wb[r_s1.id] = 1'b1;
    end else begin
      w_wb = '0;
    end
    if (w_zero) begin
      w_count = CW'(WIDTH);
    end else begin
      w_count = {1'b0, w_clz};
    end
  end

  // Control state. Grant needs !pend and handshake needs a valid slot (which
  // implies pend), so set and clear never hit the same bit in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v       <= 1'b0;
      r_pend       <= '0;
      r_resp_valid <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_s1_v       <= |w_gnt;
      r_pend       <= (r_pend & ~w_hs) | w_gnt;
      r_resp_valid <= (r_resp_valid & ~w_hs) | w_wb;
      if (|w_gnt) begin
        r_rr_ptr <= w_next_ptr;
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
    end
  end

  // Datapath registers, intentionally not reset.
  always_ff @(posedge clk) begin
    if (|w_gnt) begin
      r_s1.id   <= w_gid;
      r_s1.data <= req_data_i[w_gid];
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_wb[i]) begin
        r_slot[i] <= w_count;
      end
    end
  end

endmodule

// File: tb/tb_wired_clz_share.sv
module tb_wired_clz_share;

  localparam int W   = 32;
  localparam int N   = 4;
  localparam int CWB = 6;
  localparam int W2  = 24;
  localparam int N2  = 2;
  localparam int CW2 = 6;

  logic clk;
  logic rst_n;

  logic [N-1:0]          req_valid;
  logic [N-1:0][W-1:0]   req_data;
  logic [N-1:0]          req_ready;
  logic [N-1:0]          resp_valid;
  logic [N-1:0][CWB-1:0] resp_clz;
  logic [N-1:0]          resp_ready;

  logic [N2-1:0]          v24;
  logic [N2-1:0][W2-1:0]  d24;
  logic [N2-1:0]          rdy24;
  logic [N2-1:0]          rv24;
  logic [N2-1:0][CW2-1:0] clz24;
  logic [N2-1:0]          rr24;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Reference model state (spec level: outstanding flag, due cycle, value)
  logic m_pend [N];
  int   m_due  [N];
  int   m_exp  [N];
  int   m_ptr;

  wired_clz_share #(.WIDTH(W), .NREQ(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .resp_valid_o (resp_valid),
    .resp_clz_o   (resp_clz),
    .resp_ready_i (resp_ready)
  );

  wired_clz_share #(.WIDTH(W2), .NREQ(N2)) dut24 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (v24),
    .req_data_i   (d24),
    .req_ready_o  (rdy24),
    .resp_valid_o (rv24),
    .resp_clz_o   (clz24),
    .resp_ready_i (rr24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_clz(input logic [63:0] v, input int w);
    int n = 0;
    while (v != 64'd0) begin
      v = v >> 1;
      n++;
    end
    return w - n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0;
      m_due[i]  = 0;
      m_exp[i]  = 0;
    end
    m_ptr = 0;
  endtask

  task automatic model_step();
    int g = -1;
    logic [N-1:0] exp_gnt = '0;
    logic vis;
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        int idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx] && !m_pend[idx]) g = idx;
      end
    end
    if (g >= 0) exp_gnt[g] = 1'b1;
    chk("req_ready", req_ready, exp_gnt);
    chk("onehot", $onehot0(req_ready), 1);
    for (int i = 0; i < N; i++) begin
      vis = m_pend[i] && (cyc >= m_due[i]);
      chk($sformatf("resp_valid[%0d]", i), resp_valid[i], vis);
      if (vis) chk($sformatf("resp_clz[%0d]", i), resp_clz[i], m_exp[i]);
      if (vis && resp_ready[i]) m_pend[i] = 1'b0;
    end
    if (g >= 0) begin
      m_pend[g] = 1'b1;
      m_due[g]  = cyc + 2;
      m_exp[g]  = ref_clz(req_data[g], W);
      m_ptr     = (g + 1) % N;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_step();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_valid24", rv24, 0);
    chk("rst_req_ready", req_ready, 0);
    model_clear();
    repeat (n) begin
      at_neg();
      adv();
    end
    rst_n = 1'b1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) req_data[i] = $urandom >> $urandom_range(0, 32);
  endtask

  initial begin
    logic [CWB-1:0] held;
    logic have;
    int others;
    rst_n      = 1'b1;
    req_valid  = '1;
    req_data   = '0;
    resp_ready = '0;
    v24        = '0;
    d24        = '0;
    rr24       = '1;
    model_clear();
    #2;

    // Reset with all requesters valid: nothing may be accepted.
    do_reset(2);
    req_valid = '0;

    // Single request, result held under backpressure.
    req_valid = 4'b0001; req_data[0] = 32'h0001_0000; resp_ready = 4'b0000;
    at_neg(); chk("single_grant", req_ready, 4'b0001); adv();
    req_valid = 4'b0000;
    at_neg(); chk("single_t1", resp_valid[0], 0); adv();
    at_neg(); chk("single_valid", resp_valid, 4'b0001); chk("single_clz", resp_clz[0], 15); adv();
    repeat (3) begin
      at_neg(); chk("single_hold_v", resp_valid[0], 1); chk("single_hold_clz", resp_clz[0], 15); adv();
    end
    resp_ready = 4'b0001;
    at_neg(); adv();
    resp_ready = 4'b0000;
    at_neg(); chk("single_clear", resp_valid[0], 0); adv();

    // Zero / MSB operands, and WIDTH=24 instance.
    req_valid = 4'b1100; req_data[2] = 32'h0; req_data[3] = 32'h8000_0000; resp_ready = 4'b1111;
    v24 = 2'b11; d24[0] = 24'h0; d24[1] = 24'h00_0001;
    at_neg(); chk("zm_grant2", req_ready, 4'b0100); chk("w24_grant0", rdy24, 2'b01); adv();
    at_neg(); chk("zm_grant3", req_ready, 4'b1000); chk("w24_grant1", rdy24, 2'b10); adv();
    req_valid = 4'b0000; v24 = 2'b00;
    at_neg(); chk("zero_v", resp_valid[2], 1); chk("zero_clz", resp_clz[2], 32);
    chk("w24_zero_v", rv24[0], 1); chk("w24_zero_clz", clz24[0], 24); adv();
    at_neg(); chk("msb_v", resp_valid[3], 1); chk("msb_clz", resp_clz[3], 0);
    chk("w24_one_v", rv24[1], 1); chk("w24_one_clz", clz24[1], 23); adv();
    at_neg(); adv();

    // All four valid continuously: rotation 0,1,2,3,0,...
    do_reset(2);
    req_valid = 4'b1111; resp_ready = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      rand_data();
      at_neg(); chk($sformatf("rr_seq%0d", k), req_ready, 4'b0001 << (k % 4)); adv();
    end

    // Backpressure on requester 1.
    resp_ready = 4'b1101; have = 1'b0; held = '0; others = 0;
    for (int k = 0; k < 14; k++) begin
      rand_data();
      at_neg();
      if (resp_valid[1]) begin
        if (have) chk("bp_hold_clz", resp_clz[1], held);
        else begin held = resp_clz[1]; have = 1'b1; end
        chk("bp_no_regrant", req_ready[1], 0);
      end
      if (req_ready[0] || req_ready[2] || req_ready[3]) others++;
      adv();
    end
    chk("bp_seen", have, 1);
    chk("bp_others_issue", others >= 10, 1);
    req_valid = 4'b0010; resp_ready = 4'b1111;
    at_neg(); chk("bp_rel_valid", resp_valid[1], 1); chk("bp_rel_ready0", req_ready, 4'b0000); adv();
    at_neg(); chk("bp_regrant", req_ready, 4'b0010); adv();
    req_valid = 4'b0000;
    repeat (4) begin at_neg(); adv(); end

    // Reset one cycle after a grant; pointer must restart at 0.
    req_valid = 4'b0100; req_data[2] = $urandom;
    at_neg(); chk("mid_grant2", req_ready, 4'b0100); adv();
    req_valid = 4'b1111;
    do_reset(2);
    req_valid = 4'b1001; req_data[0] = $urandom | 32'h1;
    at_neg(); chk("rst_ptr0", req_ready, 4'b0001); adv();
    req_valid = 4'b0000;
    at_neg(); chk("rst_lat_t1", resp_valid, 4'b0000); adv();
    at_neg(); chk("rst_lat_t2", resp_valid, 4'b0001);
    chk("rst_lat_clz", resp_clz[0], ref_clz(req_data[0], W)); adv();

    // Random soak.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i]  = ($urandom_range(0, 9) < 6);
        resp_ready[i] = ($urandom_range(0, 9) < 7);
      end
      rand_data();
      at_neg(); adv();
    end
    req_valid = '0; resp_ready = '1;
    repeat (4) begin at_neg(); adv(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
